// File: rtl/updown_toggle_counter_if.sv
// Control and status bundle of the up/down counter: the master drives the
// counting controls, the slave (the counter) returns the count and its flags.
interface updown_toggle_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             at_zero;
  logic             limit;

  modport master (
    output en, up, load, load_val,
    input  count, at_max, at_zero, limit
  );

  modport slave (
    input  en, up, load, load_val,
    output count, at_max, at_zero, limit
  );
endinterface

// File: rtl/updown_toggle_counter.sv
// Up/down counter with a programmable terminal value, parallel load with
// clamping, wrap or saturate at the limits, and a one-cycle limit pulse.
module updown_toggle_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = (1 << WIDTH) - 1,
  parameter int SATURATE = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  updown_toggle_counter_if.slave    bus
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] r_count;
  logic             r_limit;
  logic [WIDTH-1:0] w_next_count;
  logic             w_next_limit;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = (r_count == MAX);
  assign w_at_zero = (r_count == '0);

  // With a full-range terminal value no loaded value can exceed it.
  generate
    if (MAX == '1) begin : g_no_clamp
      assign w_load_clamped = bus.load_val;
    end else begin : g_clamp
      assign w_load_clamped = (bus.load_val > MAX) ? MAX : bus.load_val;
    end
  endgenerate

  always_comb begin
    w_next_count = r_count;
    w_next_limit = 1'b0;
    if (bus.load) begin
      w_next_count = w_load_clamped;
    end else if (bus.en) begin
      if (bus.up) begin
        if (w_at_max) begin
          w_next_limit = 1'b1;
          if (SATURATE == 0) w_next_count = '0;
        end else begin
          w_next_count = r_count + WIDTH'(1);
        end
      end else begin
        if (w_at_zero) begin
          w_next_limit = 1'b1;
          if (SATURATE == 0) w_next_count = MAX;
        end else begin
          w_next_count = r_count - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_limit <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_limit <= w_next_limit;
    end
  end

  assign bus.count   = r_count;
  assign bus.limit   = r_limit;
  assign bus.at_max  = w_at_max;
  assign bus.at_zero = w_at_zero;
endmodule

// File: tb/tb_updown_toggle_counter.sv
// Drives four counter configurations with shared stimulus and compares each
// against an arithmetic reference model of the counting rules.
module tb_updown_toggle_counter;
  localparam int W = 4;
  localparam int N = 4;
  localparam int MAXV [N] = '{9, 9, 0, 15};
  localparam int SATV [N] = '{0, 1, 0, 0};

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_val;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  int m_cnt [N];
  int m_lim [N];

  logic [W-1:0] o_cnt [N];
  logic         o_lim [N];
  logic         o_max [N];
  logic         o_zero[N];

  updown_toggle_counter_if #(.WIDTH(W)) if0 ();
  updown_toggle_counter_if #(.WIDTH(W)) if1 ();
  updown_toggle_counter_if #(.WIDTH(W)) if2 ();
  updown_toggle_counter_if #(.WIDTH(W)) if3 ();

  assign if0.en = en; assign if0.up = up; assign if0.load = load; assign if0.load_val = load_val;
  assign if1.en = en; assign if1.up = up; assign if1.load = load; assign if1.load_val = load_val;
  assign if2.en = en; assign if2.up = up; assign if2.load = load; assign if2.load_val = load_val;
  assign if3.en = en; assign if3.up = up; assign if3.load = load; assign if3.load_val = load_val;

  assign o_cnt[0] = if0.count; assign o_lim[0] = if0.limit; assign o_max[0] = if0.at_max; assign o_zero[0] = if0.at_zero;
  assign o_cnt[1] = if1.count; assign o_lim[1] = if1.limit; assign o_max[1] = if1.at_max; assign o_zero[1] = if1.at_zero;
  assign o_cnt[2] = if2.count; assign o_lim[2] = if2.limit; assign o_max[2] = if2.at_max; assign o_zero[2] = if2.at_zero;
  assign o_cnt[3] = if3.count; assign o_lim[3] = if3.limit; assign o_max[3] = if3.at_max; assign o_zero[3] = if3.at_zero;

  updown_toggle_counter #(.WIDTH(W), .MAX_VAL(9), .SATURATE(0)) dut_wrap9 (.clk(clk), .rst_n(rst_n), .bus(if0));
  updown_toggle_counter #(.WIDTH(W), .MAX_VAL(9), .SATURATE(1)) dut_sat9  (.clk(clk), .rst_n(rst_n), .bus(if1));
  updown_toggle_counter #(.WIDTH(W), .MAX_VAL(0), .SATURATE(0)) dut_max0  (.clk(clk), .rst_n(rst_n), .bus(if2));
  updown_toggle_counter #(.WIDTH(W))                            dut_full  (.clk(clk), .rst_n(rst_n), .bus(if3));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: one clock edge of each configuration in plain integer arithmetic.
  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        m_cnt[i] = 0;
        m_lim[i] = 0;
      end else if (load) begin
        m_cnt[i] = (int'(load_val) > MAXV[i]) ? MAXV[i] : int'(load_val);
        m_lim[i] = 0;
      end else if (en) begin
        int target;
        target   = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
        m_lim[i] = 0;
        if (target > MAXV[i]) begin
          m_lim[i] = 1;
          m_cnt[i] = (SATV[i] != 0) ? m_cnt[i] : 0;
        end else if (target < 0) begin
          m_lim[i] = 1;
          m_cnt[i] = (SATV[i] != 0) ? m_cnt[i] : MAXV[i];
        end else begin
          m_cnt[i] = target;
        end
      end else begin
        m_lim[i] = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_cnt%0d", tag, i),  32'(o_cnt[i]),  32'(m_cnt[i]));
      check($sformatf("%s_lim%0d", tag, i),  32'(o_lim[i]),  32'(m_lim[i]));
      check($sformatf("%s_max%0d", tag, i),  32'(o_max[i]),  32'(m_cnt[i] == MAXV[i]));
      check($sformatf("%s_zero%0d", tag, i), 32'(o_zero[i]), 32'(m_cnt[i] == 0));
    end
  endtask

  // driver tasks
  task automatic drive(input logic d_en, input logic d_up, input logic d_load, input logic [W-1:0] d_val);
    en = d_en; up = d_up; load = d_load; load_val = d_val;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #2;
    check_all(tag);
  endtask

  // Asynchronous reset between edges, then release after one full edge in reset.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      m_lim[i] = 0;
    end
    #1;
    check_all({tag, "_async"});
    tick({tag, "_hold"});
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      m_lim[i] = 0;
    end
    repeat (2) @(posedge clk);
    #2;
    check_all("rst");
    rst_n = 1'b1;

    // T1: load 5, then assert reset between edges
    drive(1'b0, 1'b0, 1'b1, 4'd5);
    tick("t1_load");
    check("t1_loaded", 32'(o_cnt[0]), 32'd5);
    drive(1'b0, 1'b0, 1'b0, '0);
    async_reset("t1");
    check("t1_zero", 32'(o_cnt[0]), 32'd0);

    // T2: count up from 0 for 12 cycles
    drive(1'b1, 1'b1, 1'b0, '0);
    for (int k = 0; k < 12; k++) begin
      tick($sformatf("t2_%0d", k));
      if (k == 9) check("t2_wrap_limit", 32'(o_lim[0]), 32'd1);
    end
    check("t2_end", 32'(o_cnt[0]), 32'd2);

    // T3: count down from 0 for 3 cycles
    drive(1'b0, 1'b0, 1'b1, 4'd0);
    tick("t3_load");
    drive(1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 3; k++) tick($sformatf("t3_%0d", k));
    check("t3_end", 32'(o_cnt[0]), 32'd7);

    // T4: saturation at 9 then step down
    drive(1'b0, 1'b1, 1'b1, 4'd9);
    tick("t4_load");
    drive(1'b1, 1'b1, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      tick($sformatf("t4_%0d", k));
      check($sformatf("t4_sat_lim%0d", k), 32'(o_lim[1]), 32'd1);
    end
    drive(1'b1, 1'b0, 1'b0, '0);
    tick("t4_down");
    check("t4_down_cnt", 32'(o_cnt[1]), 32'd8);

    // T5: clamped load with en high, then in-range load
    drive(1'b1, 1'b1, 1'b1, 4'd14);
    tick("t5_clamp");
    check("t5_clamp_val", 32'(o_cnt[0]), 32'd9);
    drive(1'b1, 1'b0, 1'b1, 4'd3);
    tick("t5_load3");
    check("t5_load3_val", 32'(o_cnt[0]), 32'd3);

    // T6: en low with toggling up and load_val
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, k[0], 1'b0, 4'($urandom_range(0, 15)));
      tick($sformatf("t6_%0d", k));
    end

    // randomized traffic, with occasional resets
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 59) == 0) async_reset($sformatf("rnd_rst%0d", k));
      else tick($sformatf("rnd_%0d", k));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
